// File: rtl/alpha_fade_sequencer.sv
// Alpha ramp generator for a two-input blender. It steps alpha toward 0 or full scale only on
// frame boundaries, so each frame is blended with one alpha value. Commands use valid/ready.
module alpha_fade_sequencer #(
  parameter int unsigned ALPHA_W = 8,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned HOLD_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEP_W-1:0]  cmd_step,
  input  logic [HOLD_W-1:0]  cmd_frames_per_step,
  input  logic               abort,
  output logic [ALPHA_W-1:0] alpha,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SumW = ((ALPHA_W > STEP_W) ? ALPHA_W : STEP_W) + 1;
  localparam logic [ALPHA_W-1:0] AMax = '1;

  typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;

  state_e              state_q, state_d;
  logic [ALPHA_W-1:0]  alpha_q, alpha_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;

  logic [SumW-1:0]     alpha_ext, step_ext, sum;
  logic [ALPHA_W-1:0]  stepped, target, cmd_target;
  logic                accept;

  // Saturating step, computed one bit wider than either operand so it never wraps.
  always_comb begin
    alpha_ext = SumW'(alpha_q);
    step_ext  = SumW'(step_q);
    sum       = alpha_ext + step_ext;
    if (dir_q) begin
      stepped = (sum > SumW'(AMax)) ? AMax : sum[ALPHA_W-1:0];
    end else begin
      stepped = (step_ext >= alpha_ext) ? '0 : (alpha_q - step_ext[ALPHA_W-1:0]);
    end
    target     = dir_q ? AMax : '0;
    cmd_target = cmd_dir ? AMax : '0;
  end

  always_comb begin
    state_d   = state_q;
    alpha_d   = alpha_q;
    dir_d     = dir_q;
    step_d    = step_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    cmd_ready = (state_q == StIdle) && !abort;
    accept    = cmd_valid && cmd_ready;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dir_d   = cmd_dir;
          step_d  = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
          hold_d  = (cmd_frames_per_step == '0) ? HOLD_W'(1) : cmd_frames_per_step;
          cnt_d   = '0;
          state_d = (alpha_q == cmd_target) ? StDone : StRamp;
        end
      end
      StRamp: begin
        // Abort wins over a coincident frame step; alpha is left where it is.
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (frame_start) begin
          if (cnt_q == hold_q - HOLD_W'(1)) begin
            cnt_d   = '0;
            alpha_d = stepped;
            if (stepped == target) begin
              state_d = StDone;
            end
          end else begin
            cnt_d = cnt_q + HOLD_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      alpha_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= STEP_W'(1);
      hold_q  <= HOLD_W'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alpha = alpha_q;
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);

endmodule
